// File: rtl/ccis_mem_responder.sv
// ccis_mem_responder: CCI-S host model. AFU reads (c0 Tx) and writes (c1 Tx)
// hit a local line memory; responses queue in per-channel FIFOs and drain
// on c0/c1 Rx unless rsp_stall holds them back. Back-pressure to the AFU is
// only the registered almost-full outputs.
// Optional feature: define CCIS_RESP_INTR_EN to serve tx1.intrValid as an
// interrupt response on rx1; otherwise interrupts are dropped and flagged.
// Handshake: a request is taken on any cycle its valid is high (no ready);
// a response is presented for exactly one cycle with its valid high.

package ccis_pkg;
    typedef enum logic [3:0] {
        CCIS_RSP_RD   = 4'h0,
        CCIS_RSP_WR   = 4'h1,
        CCIS_RSP_INTR = 4'h8
    } t_ccis_rsp_type;

    typedef struct packed {
        logic [31:0] cl_addr;
        logic [15:0] mdata;
    } t_ccis_req_hdr;

    typedef struct packed {
        logic [7:0]     rsvd;
        t_ccis_rsp_type resp_type;
        logic [15:0]    mdata;
    } t_ccis_rsp_hdr;

    typedef struct packed {
        t_ccis_req_hdr hdr;
        logic          rdValid;
    } t_if_ccis_c0_Tx;

    typedef struct packed {
        t_ccis_req_hdr hdr;
        logic [511:0]  data;
        logic          wrValid;
        logic          intrValid;
    } t_if_ccis_c1_Tx;

    typedef struct packed {
        t_ccis_rsp_hdr hdr;
        logic [511:0]  data;
        logic          wrValid;
        logic          rdValid;
        logic          cfgValid;
        logic          umsgValid;
        logic          intrValid;
    } t_if_ccis_c0_Rx;

    typedef struct packed {
        t_ccis_rsp_hdr hdr;
        logic          wrValid;
        logic          intrValid;
    } t_if_ccis_c1_Rx;
endpackage

// Response FIFO: drops pushes when full unless a pop frees a slot the same cycle.
module ccis_resp_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16,
    parameter int SLACK = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         almfull_o,
    output logic         overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          almfull_q;
    logic          full, push_ok;

    assign full       = (count_q == CW'(DEPTH));
    assign push_ok    = push_i && (!full || pop_i);
    assign overflow_o = push_i && full && !pop_i;
    assign count_d    = count_q + CW'(push_ok) - CW'(pop_i);
    assign empty_o    = (count_q == '0);
    assign dout_o     = mem_q[rd_ptr_q];
    assign almfull_o  = almfull_q;

    // Storage is not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers, occupancy and registered almost-full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            almfull_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            almfull_q <= (count_d >= CW'(DEPTH - SLACK));
        end
    end
endmodule

module ccis_mem_responder
    import ccis_pkg::*;
#(
    parameter int ADDR_BITS     = 10,
    parameter int FIFO_DEPTH    = 16,
    parameter int ALMFULL_SLACK = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  t_if_ccis_c0_Tx tx0,
    input  t_if_ccis_c1_Tx tx1,
    output logic           c0TxAlmFull,
    output logic           c1TxAlmFull,
    output t_if_ccis_c0_Rx rx0,
    output t_if_ccis_c1_Rx rx1,
    input  logic           rsp_stall,
    output logic           err_overflow,
    output logic           err_intr
);
    localparam int RW = 16 + 512;
    localparam int WW = 1 + 16;

    logic                 rd_q, wr_q, intr_q;
    logic [ADDR_BITS-1:0] rd_addr_q, wr_addr_q;
    logic [15:0]          rd_mdata_q, wr_mdata_q;
    logic [511:0]         wr_data_q;
    logic [511:0]         mem_q [2**ADDR_BITS];
    logic [511:0]         rd_data;

    logic          w_push, w_is_intr, intr_bad;
    logic          r_pop, w_pop, r_empty, w_empty, r_ovf, w_ovf;
    logic [RW-1:0] r_dout;
    logic [WW-1:0] w_dout;
    logic          err_overflow_q, err_intr_q;
    t_if_ccis_c0_Rx rx0_q;
    t_if_ccis_c1_Rx rx1_q;

    // Request stage: sample the AFU requests; upper address bits alias away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            intr_q     <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_mdata_q <= '0;
            wr_mdata_q <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_q       <= tx0.rdValid;
            wr_q       <= tx1.wrValid;
            intr_q     <= tx1.intrValid;
            rd_addr_q  <= tx0.hdr.cl_addr[ADDR_BITS-1:0];
            wr_addr_q  <= tx1.hdr.cl_addr[ADDR_BITS-1:0];
            rd_mdata_q <= tx0.hdr.mdata;
            wr_mdata_q <= tx1.hdr.mdata;
            wr_data_q  <= tx1.data;
        end
    end

    // Line memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_q) mem_q[wr_addr_q] <= wr_data_q;
    end

    // Write-first: a same-cycle write to the read line forwards its data.
    assign rd_data = (wr_q && (wr_addr_q == rd_addr_q)) ? wr_data_q : mem_q[rd_addr_q];

`ifdef CCIS_RESP_INTR_EN
    assign w_push    = wr_q || intr_q;
    assign w_is_intr = !wr_q;
    assign intr_bad  = intr_q && wr_q;
`else
    assign w_push    = wr_q;
    assign w_is_intr = 1'b0;
    assign intr_bad  = intr_q;
`endif

    assign r_pop = !rsp_stall && !r_empty;
    assign w_pop = !rsp_stall && !w_empty;

    ccis_resp_fifo #(.W(RW), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)) u_rd_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(rd_q), .din_i({rd_mdata_q, rd_data}),
        .pop_i(r_pop), .dout_o(r_dout), .empty_o(r_empty), .almfull_o(c0TxAlmFull),
        .overflow_o(r_ovf)
    );

    ccis_resp_fifo #(.W(WW), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)) u_wr_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(w_push), .din_i({w_is_intr, wr_mdata_q}),
        .pop_i(w_pop), .dout_o(w_dout), .empty_o(w_empty), .almfull_o(c1TxAlmFull),
        .overflow_o(w_ovf)
    );

    // Response registers: one-cycle valid per popped entry, valids clear otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx0_q <= '0;
            rx1_q <= '0;
        end else begin
            rx0_q.rdValid   <= r_pop;
            rx0_q.wrValid   <= 1'b0;
            rx0_q.cfgValid  <= 1'b0;
            rx0_q.umsgValid <= 1'b0;
            rx0_q.intrValid <= 1'b0;
            if (r_pop) begin
                rx0_q.hdr.rsvd      <= '0;
                rx0_q.hdr.resp_type <= CCIS_RSP_RD;
                rx0_q.hdr.mdata     <= r_dout[RW-1:512];
                rx0_q.data          <= r_dout[511:0];
            end
`ifdef CCIS_RESP_INTR_EN
            rx1_q.wrValid   <= w_pop && !w_dout[16];
            rx1_q.intrValid <= w_pop && w_dout[16];
            if (w_pop) begin
                rx1_q.hdr.rsvd      <= '0;
                rx1_q.hdr.resp_type <= w_dout[16] ? CCIS_RSP_INTR : CCIS_RSP_WR;
                rx1_q.hdr.mdata     <= w_dout[15:0];
            end
`else
            rx1_q.wrValid   <= w_pop;
            rx1_q.intrValid <= 1'b0;
            if (w_pop) begin
                rx1_q.hdr.rsvd      <= '0;
                rx1_q.hdr.resp_type <= CCIS_RSP_WR;
                rx1_q.hdr.mdata     <= w_dout[15:0];
            end
`endif
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow_q <= 1'b0;
            err_intr_q     <= 1'b0;
        end else begin
            err_overflow_q <= err_overflow_q | r_ovf | w_ovf;
            err_intr_q     <= err_intr_q | intr_bad;
        end
    end

    assign rx0          = rx0_q;
    assign rx1          = rx1_q;
    assign err_overflow = err_overflow_q;
    assign err_intr     = err_intr_q;

    logic unused_ok;
`ifdef CCIS_RESP_INTR_EN
    assign unused_ok = ^{tx0.hdr.cl_addr[31:ADDR_BITS], tx1.hdr.cl_addr[31:ADDR_BITS]};
`else
    assign unused_ok = ^{tx0.hdr.cl_addr[31:ADDR_BITS], tx1.hdr.cl_addr[31:ADDR_BITS], w_dout[16]};
`endif
endmodule

// File: tb/tb_ccis_mem_responder.sv
// Bench for ccis_mem_responder: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based model.
module tb_ccis_mem_responder;
    import ccis_pkg::*;

    localparam int AB    = 10;
    localparam int DEPTH = 16;
    localparam int SLACK = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           rsp_stall = 1'b0;
    t_if_ccis_c0_Tx tx0;
    t_if_ccis_c1_Tx tx1;
    logic           c0TxAlmFull, c1TxAlmFull, err_overflow, err_intr;
    t_if_ccis_c0_Rx rx0;
    t_if_ccis_c1_Rx rx1;

    int n_cmp = 0;
    int n_fail = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    ccis_mem_responder #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
        .clk(clk), .reset_n(reset_n), .tx0(tx0), .tx1(tx1),
        .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
        .rx0(rx0), .rx1(rx1), .rsp_stall(rsp_stall),
        .err_overflow(err_overflow), .err_intr(err_intr)
    );

    task automatic check(input string name, input logic [527:0] got, input logic [527:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: queues of outstanding responses, memory as a sparse map.
    typedef struct packed { logic known; logic [15:0] mdata; logic [511:0] data; } rd_ent_t;
    typedef struct packed { logic intr; logic [15:0] mdata; } wr_ent_t;

    rd_ent_t      q0[$];
    wr_ent_t      q1[$];
    logic [511:0] mmem [int];
    rd_ent_t      e_rd, n_rd;
    wr_ent_t      e_w, n_w;
    logic         e_rd_v = 0, e_w_v = 0, e_af0 = 0, e_af1 = 0, e_ovf = 0, e_eint = 0;
    logic         p_rd = 0, p_wr = 0, p_intr = 0;
    int           p_raddr = 0, p_waddr = 0;
    logic [15:0]  p_rmdata = 0, p_wmdata = 0;
    logic [511:0] p_wdata = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q0.delete(); q1.delete();
            p_rd = 0; p_wr = 0; p_intr = 0;
            e_rd_v = 0; e_w_v = 0; e_af0 = 0; e_af1 = 0; e_ovf = 0; e_eint = 0;
        end else begin
            // responses leave first, so a full queue can take a push this cycle
            e_rd_v = 0;
            if (!rsp_stall && q0.size() > 0) begin e_rd = q0.pop_front(); e_rd_v = 1; end
            e_w_v = 0;
            if (!rsp_stall && q1.size() > 0) begin e_w = q1.pop_front(); e_w_v = 1; end
            // requests sampled last edge take effect now; write lands before the read
            if (p_wr) mmem[p_waddr] = p_wdata;
            if (p_rd) begin
                n_rd.known = mmem.exists(p_raddr);
                n_rd.data  = n_rd.known ? mmem[p_raddr] : '0;
                n_rd.mdata = p_rmdata;
                if (q0.size() < DEPTH) q0.push_back(n_rd); else e_ovf = 1;
            end
            n_w.mdata = p_wmdata;
            if (p_wr) begin
                n_w.intr = 0;
                if (q1.size() < DEPTH) q1.push_back(n_w); else e_ovf = 1;
                if (p_intr) e_eint = 1;
            end else if (p_intr) begin
`ifdef CCIS_RESP_INTR_EN
                n_w.intr = 1;
                if (q1.size() < DEPTH) q1.push_back(n_w); else e_ovf = 1;
`else
                e_eint = 1;
`endif
            end
            e_af0 = (q0.size() >= DEPTH - SLACK);
            e_af1 = (q1.size() >= DEPTH - SLACK);
            p_rd     = tx0.rdValid;
            p_raddr  = int'(tx0.hdr.cl_addr % (32'd1 << AB));
            p_rmdata = tx0.hdr.mdata;
            p_wr     = tx1.wrValid;
            p_intr   = tx1.intrValid;
            p_waddr  = int'(tx1.hdr.cl_addr % (32'd1 << AB));
            p_wmdata = tx1.hdr.mdata;
            p_wdata  = tx1.data;
        end
    end

    // Scoreboard compare on every falling edge while out of reset
    always @(negedge clk) begin
        if (reset_n) begin
            check("rx0_rdValid", rx0.rdValid, e_rd_v);
            if (e_rd_v && rx0.rdValid) begin
                check("rx0_mdata", rx0.hdr.mdata, e_rd.mdata);
                check("rx0_type", rx0.hdr.resp_type, CCIS_RSP_RD);
                check("rx0_rsvd", rx0.hdr.rsvd, 0);
                if (e_rd.known) check("rx0_data", rx0.data, e_rd.data);
            end
            check("rx0_other_valids", {rx0.wrValid, rx0.cfgValid, rx0.umsgValid, rx0.intrValid}, 0);
            check("rx1_wrValid", rx1.wrValid, e_w_v && !e_w.intr);
            check("rx1_intrValid", rx1.intrValid, e_w_v && e_w.intr);
            if (e_w_v && (rx1.wrValid || rx1.intrValid)) begin
                check("rx1_mdata", rx1.hdr.mdata, e_w.mdata);
                check("rx1_type", rx1.hdr.resp_type, e_w.intr ? CCIS_RSP_INTR : CCIS_RSP_WR);
                check("rx1_rsvd", rx1.hdr.rsvd, 0);
            end
            check("c0TxAlmFull", c0TxAlmFull, e_af0);
            check("c1TxAlmFull", c1TxAlmFull, e_af1);
            check("err_overflow", err_overflow, e_ovf);
            check("err_intr", err_intr, e_eint);
        end
    end

    // Driver helpers
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_idle();
        tx0 = '0;
        tx1 = '0;
    endtask

    task automatic set_read(input logic [31:0] addr, input logic [15:0] md);
        tx0.rdValid = 1'b1;
        tx0.hdr.cl_addr = addr;
        tx0.hdr.mdata = md;
    endtask

    task automatic set_write(input logic [31:0] addr, input logic [15:0] md, input logic [511:0] d);
        tx1.wrValid = 1'b1;
        tx1.hdr.cl_addr = addr;
        tx1.hdr.mdata = md;
        tx1.data = d;
    endtask

    logic [511:0] a5_line;
    int           cnt;
    logic [15:0]  last_md;

    initial begin
        set_idle();
        a5_line = {64{8'hA5}};
        cyc(3);
        check("lit_reset_rx0_rdValid", rx0.rdValid, 0);
        check("lit_reset_rx1_wrValid", rx1.wrValid, 0);
        check("lit_reset_rx1_intrValid", rx1.intrValid, 0);
        check("lit_reset_almfull", {c0TxAlmFull, c1TxAlmFull}, 0);
        check("lit_reset_errs", {err_overflow, err_intr}, 0);
        #2 reset_n = 1'b1;
        cyc(1);

        // Write A5 to line 3, then read it back
        set_write(32'h3, 16'h12, a5_line);
        cyc(1);
        set_idle();
        set_read(32'h3, 16'h34);
        cyc(1);
        check("lit_wr_not_at_1", rx1.wrValid, 0);
        set_idle();
        cyc(1);
        check("lit_wr_valid_at_2", rx1.wrValid, 1);
        check("lit_wr_mdata", rx1.hdr.mdata, 16'h12);
        cyc(1);
        check("lit_rd_valid_at_2", rx0.rdValid, 1);
        check("lit_rd_mdata", rx0.hdr.mdata, 16'h34);
        check("lit_rd_data", rx0.data, a5_line);

        // Same-cycle write and read of line 7 returns the new data
        set_write(32'h7, 16'h13, 512'h1);
        set_read(32'h7, 16'h35);
        cyc(1);
        set_idle();
        cyc(2);
        check("lit_wf_valid", rx0.rdValid, 1);
        check("lit_wf_data", rx0.data, 512'h1);

        // Stalled 12 reads: almost-full at occupancy 12, then in-order drain
        rsp_stall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_read(32'(i), 16'(16'h100 + i));
            cyc(1);
        end
        check("lit_af_at_11", c0TxAlmFull, 0);
        set_idle();
        cyc(1);
        check("lit_af_at_12", c0TxAlmFull, 1);
        cyc(1);
        rsp_stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            check("lit_drain_valid", rx0.rdValid, 1);
            check("lit_drain_mdata", rx0.hdr.mdata, 16'(16'h100 + i));
        end
        cyc(1);
        check("lit_drain_done", rx0.rdValid, 0);
        check("lit_no_ovf_yet", err_overflow, 0);

        // 17 stalled reads: 17th dropped, overflow flagged
        rsp_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_read(32'(i), 16'(16'h200 + i));
            cyc(1);
        end
        set_idle();
        cyc(2);
        check("lit_ovf_set", err_overflow, 1);
        rsp_stall = 1'b0;
        cnt = 0;
        last_md = '0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (rx0.rdValid) begin cnt++; last_md = rx0.hdr.mdata; end
        end
        check("lit_ovf_count", 528'(cnt), 16);
        check("lit_ovf_last_mdata", last_md, 16'h20F);

        // Interrupt request
        tx1.intrValid = 1'b1;
        tx1.hdr.mdata = 16'h5;
        cyc(1);
        set_idle();
        cyc(2);
`ifdef CCIS_RESP_INTR_EN
        check("lit_intr_valid", rx1.intrValid, 1);
        check("lit_intr_wrValid", rx1.wrValid, 0);
        check("lit_intr_mdata", rx1.hdr.mdata, 16'h5);
        check("lit_intr_err", err_intr, 0);
`else
        check("lit_intr_none", {rx1.intrValid, rx1.wrValid}, 0);
        check("lit_intr_err", err_intr, 1);
`endif
        cyc(2);

        // Randomized traffic with aliasing upper address bits
        for (int c = 0; c < 600; c++) begin
            int r;
            set_idle();
            rsp_stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 1) == 1)
                set_read(($urandom() & ~32'h3FF) | 32'($urandom_range(0, 15)), 16'($urandom()));
            r = $urandom_range(0, 19);
            if (r < 12) begin
                set_write(($urandom() & ~32'h3FF) | 32'($urandom_range(0, 15)), 16'($urandom()), '0);
                for (int k = 0; k < 16; k++) tx1.data[k*32 +: 32] = $urandom();
            end
            if (r == 11 || r == 12) begin
                tx1.intrValid = 1'b1;
                tx1.hdr.mdata = 16'($urandom());
            end
            cyc(1);
        end
        set_idle();
        rsp_stall = 1'b0;
        cyc(20);

        // Reset with responses queued and one on the wire
        rsp_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_read(32'h3, 16'(16'h300 + i));
            cyc(1);
        end
        set_idle();
        cyc(2);
        rsp_stall = 1'b0;
        cyc(1);
        #2 reset_n = 1'b0;
        #1;
        check("lit_rst_rx0_async", rx0.rdValid, 0);
        check("lit_rst_rx1_async", {rx1.wrValid, rx1.intrValid}, 0);
        cyc(2);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check("lit_post_rst_quiet", {rx0.rdValid, rx1.wrValid, rx1.intrValid}, 0);
        end
        check("lit_post_rst_af", {c0TxAlmFull, c1TxAlmFull}, 0);
        check("lit_post_rst_errs", {err_overflow, err_intr}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
